// File: rtl/fb_rect_writer_if.sv
// Command/write-port bundle for fb_rect_writer.
//   master : command side (start, rectangle, colour, hold) -> engine
//   slave  : engine side  (busy, done, frame-buffer write port) -> outside
interface fb_rect_writer_if #(parameter int ADDR_W = 15);
  logic              start;
  logic [7:0]        x0;
  logic [6:0]        y0;
  logic [7:0]        w;
  logic [6:0]        h;
  logic [11:0]       color;
  logic              hold;
  logic              busy;
  logic              done;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [11:0]       din;

  modport master (output start, x0, y0, w, h, color, hold,
                  input  busy, done, we, addr, din);
  modport slave  (input  start, x0, y0, w, h, color, hold,
                  output busy, done, we, addr, din);
endinterface

// File: rtl/fb_rect_writer.sv
// Rectangle-fill engine for the 160x120 background frame buffer.
// Writes one pixel per clock at addr = x + FB_W*y with a solid RGB444 colour.
// Ports:
//   clk, rst : single clock, asynchronous active-high reset
//   bus      : slave side of fb_rect_writer_if
//              start/x0/y0/w/h/color in, hold stall in,
//              busy/done status out, we/addr/din frame-buffer write port out
// Rectangles are clipped to the buffer; zero-area commands just pulse done.
module fb_rect_writer #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int ADDR_W = 15
) (
  input  logic           clk,
  input  logic           rst,
  fb_rect_writer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t            state;
  logic [7:0]        x, x_org, x_last;
  logic [6:0]        y, y_last;
  logic [ADDR_W-1:0] row_base;
  logic [11:0]       col;

  // Clip arithmetic on one-bit-wider values so x0+w style sums never wrap.
  logic [8:0] x_room, cw;
  logic [7:0] y_room, ch;
  logic [7:0] x_end;
  logic [6:0] y_end;

  always_comb begin
    x_room = 9'(FB_W) - {1'b0, bus.x0};
    y_room = 8'(FB_H) - {1'b0, bus.y0};
    cw     = '0;
    ch     = '0;
    if ({1'b0, bus.x0} < 9'(FB_W))
      cw = ({1'b0, bus.w} < x_room) ? {1'b0, bus.w} : x_room;
    if ({1'b0, bus.y0} < 8'(FB_H))
      ch = ({1'b0, bus.h} < y_room) ? {1'b0, bus.h} : y_room;
    // Only meaningful when the clipped size is non-zero.
    x_end  = bus.x0 + cw[7:0] - 8'd1;
    y_end  = bus.y0 + ch[6:0] - 7'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.we   <= 1'b0;
      bus.addr <= '0;
      bus.din  <= '0;
      x        <= '0;
      x_org    <= '0;
      x_last   <= '0;
      y        <= '0;
      y_last   <= '0;
      row_base <= '0;
      col      <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.we   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            col    <= bus.color;
            x      <= bus.x0;
            x_org  <= bus.x0;
            x_last <= x_end;
            y      <= bus.y0;
            y_last <= y_end;
            // The only multiply: once per command, never inside the pixel loop.
            row_base <= ADDR_W'(FB_W) * ADDR_W'(bus.y0);
            state    <= (cw == '0 || ch == '0) ? DONE : FILL;
          end
        end
        FILL: begin
          bus.busy <= 1'b1;
          // On hold, we drops (default above) and addr/din keep their values.
          if (!bus.hold) begin
            bus.we   <= 1'b1;
            bus.addr <= row_base + ADDR_W'(x);
            bus.din  <= col;
            if (x == x_last) begin
              x        <= x_org;
              y        <= y + 7'd1;
              row_base <= row_base + ADDR_W'(FB_W);
              if (y == y_last) state <= DONE;
            end else begin
              x <= x + 8'd1;
            end
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
module tb_fb_rect_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fb_rect_writer_if #(.ADDR_W(15)) bus ();

  fb_rect_writer #(.FB_W(160), .FB_H(120), .ADDR_W(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: every pixel of the clipped rectangle, row-major.
  task automatic build_exp(input int ax0, ay0, aw, ah, output int q[$]);
    int cw, ch;
    q = {};
    cw = (ax0 >= 160) ? 0 : ((aw < 160 - ax0) ? aw : 160 - ax0);
    ch = (ay0 >= 120) ? 0 : ((ah < 120 - ay0) ? ah : 120 - ay0);
    for (int yy = ay0; yy < ay0 + ch; yy++)
      for (int xx = ax0; xx < ax0 + cw; xx++)
        q.push_back(xx + 160 * yy);
  endtask

  task automatic drive_cmd(input int ax0, ay0, aw, ah, acol);
    bus.x0    = 8'(ax0);
    bus.y0    = 7'(ay0);
    bus.w     = 8'(aw);
    bus.h     = 7'(ah);
    bus.color = 12'(acol);
    bus.start = 1'b1;
    bus.hold  = 1'b0;
  endtask

  // Issue one command and watch it to completion. hmode stalls every third
  // cycle; mstart fires a different command while the fill is running.
  task automatic run_cmd(input int ax0, ay0, aw, ah, acol,
                         input bit hmode, input bit mstart, input string tag);
    int exp_q[$];
    int got_a[$];
    int got_d[$];
    int t, holds, busy_n, done_t, bad, bad_d, first_bad, n, limit;
    bit hh;
    build_exp(ax0, ay0, aw, ah, exp_q);
    n = exp_q.size();
    limit = 2 * n + 20;
    t = 0; holds = 0; busy_n = 0; done_t = -1; first_bad = -1;
    @(negedge clk);
    drive_cmd(ax0, ay0, aw, ah, acol);
    @(negedge clk);              // start accepted at the edge just passed
    bus.start = 1'b0;
    while (done_t < 0 && t < limit) begin
      hh = hmode && (t % 3 == 2);
      bus.hold = hh;
      if (hh && got_a.size() < n) holds++;
      if (mstart && t == 2) begin
        bus.start = 1'b1; bus.x0 = 8'd0; bus.y0 = 7'd0;
        bus.w = 8'd50; bus.h = 7'd50; bus.color = 12'h123;
      end
      if (mstart && t == 3) bus.start = 1'b0;
      @(negedge clk);
      t++;
      if (bus.we === 1'b1) begin
        got_a.push_back(int'(bus.addr));
        got_d.push_back(int'(bus.din));
      end
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) done_t = t;
    end
    bus.hold  = 1'b0;
    bus.start = 1'b0;
    chk({tag, " done_latency"}, done_t, n + 1 + holds);
    chk({tag, " busy_cycles"}, busy_n, n + holds);
    chk({tag, " write_count"}, got_a.size(), n);
    bad = 0; bad_d = 0;
    for (int i = 0; i < got_a.size() && i < n; i++) begin
      if (got_a[i] != exp_q[i]) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
      if (got_d[i] != acol) bad_d++;
    end
    chk({tag, " addr_mismatches"}, bad, 0);
    if (first_bad >= 0)
      chk({tag, " first_bad_addr"}, got_a[first_bad], exp_q[first_bad]);
    chk({tag, " din_mismatches"}, bad_d, 0);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, int'(bus.done), 0);
  endtask

  initial begin
    int q[$];
    int wcnt, t, extra;
    bus.start = 1'b0; bus.hold = 1'b0;
    bus.x0 = '0; bus.y0 = '0; bus.w = '0; bus.h = '0; bus.color = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst done", int'(bus.done), 0);
    chk("rst we",   int'(bus.we),   0);
    chk("rst addr", int'(bus.addr), 0);
    chk("rst din",  int'(bus.din),  0);
    rst = 1'b0;

    // Directed cases
    run_cmd(10, 5, 2, 2, 12'hF00, 1'b0, 1'b0, "basic");
    run_cmd(158, 119, 4, 3, 12'h0F0, 1'b0, 1'b0, "clip_corner");
    run_cmd(200, 10, 5, 5, 12'h00F, 1'b0, 1'b0, "clip_x_off");
    run_cmd(10, 125, 5, 5, 12'h00F, 1'b0, 1'b0, "clip_y_off");
    run_cmd(20, 20, 0, 5, 12'hABC, 1'b0, 1'b0, "zero_w");
    run_cmd(3, 4, 20, 3, 12'h0A5, 1'b0, 1'b1, "start_busy");
    run_cmd(0, 0, 255, 127, 12'h5A5, 1'b1, 1'b0, "full_hold");

    // Randomized commands
    for (int i = 0; i < 10; i++)
      run_cmd($urandom_range(0, 170), $urandom_range(0, 125),
              $urandom_range(0, 12), $urandom_range(0, 8),
              $urandom_range(0, 4095), 1'($urandom_range(0, 1)), 1'b0, "random");

    // Reset in the middle of a fill
    build_exp(0, 0, 40, 10, q);
    @(negedge clk);
    drive_cmd(0, 0, 40, 10, 12'h777);
    @(negedge clk);
    bus.start = 1'b0;
    wcnt = 0; t = 0;
    while (wcnt < 7 && t < 50) begin
      @(negedge clk);
      t++;
      if (bus.we === 1'b1) begin
        chk("midrst prefix_addr", int'(bus.addr), q[wcnt]);
        wcnt++;
      end
    end
    chk("midrst writes_before", wcnt, 7);
    #2 rst = 1'b1;
    #1;
    chk("midrst we",   int'(bus.we),   0);
    chk("midrst busy", int'(bus.busy), 0);
    chk("midrst addr", int'(bus.addr), 0);
    chk("midrst din",  int'(bus.din),  0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.we === 1'b1 || bus.busy === 1'b1) extra++;
    end
    chk("midrst quiet_after", extra, 0);
    run_cmd(10, 5, 2, 2, 12'h0FF, 1'b0, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
